// File: rtl/imem_load_controller_if.sv
// Bundle of host load, CPU fetch and instruction memory signals for imem_load_controller.
// The slave modport is the controller's view; the master modport is the host/CPU/memory side.
interface imem_load_controller_if #(
    parameter int N  = 32,
    parameter int IM = 5
);
    logic          LoadValid;
    logic [N-1:0]  LoadData;
    logic          LoadLast;
    logic          LoadReady;
    logic          Reload;

    logic          FetchReq;
    logic [IM-1:0] FetchAddress;
    logic          FetchValid;
    logic [N-1:0]  FetchInstruction;
    logic          CpuStall;

    logic          MemWe;
    logic [IM-1:0] MemAddr;
    logic [N-1:0]  MemWData;
    logic [N-1:0]  MemRData;

    logic [IM:0]   WordCount;
    logic          OverflowErr;

    modport slave (
        input  LoadValid, LoadData, LoadLast, Reload,
        input  FetchReq, FetchAddress, MemRData,
        output LoadReady, FetchValid, FetchInstruction, CpuStall,
        output MemWe, MemAddr, MemWData, WordCount, OverflowErr
    );

    modport master (
        output LoadValid, LoadData, LoadLast, Reload,
        output FetchReq, FetchAddress, MemRData,
        input  LoadReady, FetchValid, FetchInstruction, CpuStall,
        input  MemWe, MemAddr, MemWData, WordCount, OverflowErr
    );
endinterface

// File: rtl/imem_load_controller.sv
// Instruction memory load controller: streams a program into IMEM, then serves CPU fetches.
// Optional feature macro IMEM_ZERO_FILL_EN: zero-fill the unused tail of IMEM after a load.
module imem_load_controller #(
    parameter int N  = 32,
    parameter int IM = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    imem_load_controller_if.slave bus
);

    localparam logic [IM-1:0] LAST_ADDR  = {IM{1'b1}};
    localparam logic [IM:0]   FULL_COUNT = {1'b1, {IM{1'b0}}};

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic [IM-1:0] r_ptr;
    logic [IM:0]   r_word_count;
    logic          r_overflow;
    logic          r_fetch_valid;
    logic [N-1:0]  r_fetch_instr;

    logic          w_load_hs;
    logic          w_fill_we;
    logic          w_fetch_take;
    logic          w_at_last;

    assign w_at_last = (r_ptr == LAST_ADDR);

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= LOAD;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every signal gets a default before the case, so no path leaves one unassigned (no latch).
    always_comb begin
        w_next_state = r_state;
        w_load_hs    = 1'b0;
        w_fill_we    = 1'b0;
        w_fetch_take = 1'b0;
        case (r_state)
            LOAD: begin
                w_load_hs = bus.LoadValid;
                if (w_load_hs) begin
                    if (bus.LoadLast) begin
`ifdef IMEM_ZERO_FILL_EN
                        w_next_state = w_at_last ? RUN : FILL;
`else
                        w_next_state = RUN;
`endif
                    end else if (w_at_last) begin
                        w_next_state = RUN;
                    end
                end
            end
            FILL: begin
                w_fill_we = 1'b1;
                if (w_at_last) begin
                    w_next_state = RUN;
                end
            end
            RUN: begin
                w_fetch_take = bus.FetchReq;
                if (bus.Reload) begin
                    w_next_state = DRAIN;
                end
            end
            DRAIN: begin
                w_next_state = LOAD;
            end
            default: begin
                w_next_state = LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr         <= '0;
            r_word_count  <= '0;
            r_overflow    <= 1'b0;
            r_fetch_valid <= 1'b0;
            r_fetch_instr <= '0;
        end else begin
            r_fetch_valid <= w_fetch_take;
            if (w_fetch_take) begin
                r_fetch_instr <= bus.MemRData;
            end

            if (w_load_hs || w_fill_we) begin
                r_ptr <= r_ptr + 1'b1;
            end
            if (w_load_hs && (r_word_count != FULL_COUNT)) begin
                r_word_count <= r_word_count + 1'b1;
            end
            // A full memory without an end marker means the program did not fit.
            if (w_load_hs && w_at_last && !bus.LoadLast) begin
                r_overflow <= 1'b1;
            end

            if (r_state == DRAIN) begin
                r_ptr        <= '0;
                r_word_count <= '0;
            end
        end
    end

    // NOTE: write strobes are gated by rst_n so a held LoadValid cannot write while reset is asserted.
    assign bus.LoadReady        = (r_state == LOAD);
    assign bus.CpuStall         = (r_state != RUN);
    assign bus.MemWe            = rst_n & (w_load_hs | w_fill_we);
    assign bus.MemAddr          = (r_state == RUN) ? bus.FetchAddress : r_ptr;
    assign bus.MemWData         = (rst_n && w_load_hs) ? bus.LoadData : '0;
    assign bus.FetchValid       = r_fetch_valid;
    assign bus.FetchInstruction = r_fetch_instr;
    assign bus.WordCount        = r_word_count;
    assign bus.OverflowErr      = r_overflow;

endmodule

// File: tb/tb_imem_load_controller.sv
// Scoreboard bench for imem_load_controller: random program loads and fetches against a
// program-image model; a negedge monitor pops expected fetch results from a queue.
module tb_imem_load_controller;
    localparam int N     = 32;
    localparam int IM    = 5;
    localparam int DEPTH = 1 << IM;

    typedef struct {
        logic [N-1:0] data;
        int           due;
    } fetch_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    imem_load_controller_if #(.N(N), .IM(IM)) bus ();
    imem_load_controller #(.N(N), .IM(IM)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [N-1:0] mem      [DEPTH];
    logic [N-1:0] seed_mem [DEPTH];
    logic [N-1:0] exp_mem  [DEPTH];
    bit           mem_seeded;
    bit           exp_ovf;
    fetch_t       sb_q [$];
    logic [N-1:0] last_data;
    int           cyc;
    int           vectors;
    int           miscompares;

    // Instruction memory attached to the controller, preloaded with "prior contents".
    always @(posedge clk) begin
        if (!mem_seeded) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= seed_mem[i];
            mem_seeded <= 1'b1;
        end else if (bus.MemWe) begin
            mem[bus.MemAddr] <= bus.MemWData;
        end
    end
    assign bus.MemRData = mem[bus.MemAddr];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: fetch results are due exactly one cycle after the request.
    always @(negedge clk) begin
        if (!rst_n) begin
            last_data = '0;
        end else if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            check("fetch_valid", bus.FetchValid, 1);
            check("fetch_data", bus.FetchInstruction, sb_q[0].data);
            last_data = sb_q[0].data;
            void'(sb_q.pop_front());
        end else begin
            check("fetch_idle_valid", bus.FetchValid, 0);
            check("fetch_hold", bus.FetchInstruction, last_data);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_words(input int n, input bit last);
        logic [N-1:0] d;
        int gaps;
        for (int i = 0; i < n; i++) begin
            gaps = $urandom_range(0, 2);
            for (int g = 0; g < gaps; g++) begin
                bus.LoadValid    = 1'b0;
                bus.Reload       = 1'($urandom_range(0, 1));
                bus.FetchReq     = 1'($urandom_range(0, 1));
                bus.FetchAddress = IM'($urandom_range(0, DEPTH - 1));
                @(negedge clk);
                check("idle_mem_we", bus.MemWe, 0);
                step();
            end
            bus.Reload    = 1'b0;
            bus.FetchReq  = 1'b0;
            d             = $urandom;
            bus.LoadValid = 1'b1;
            bus.LoadData  = d;
            bus.LoadLast  = last && (i == n - 1);
            @(negedge clk);
            check("load_ready", bus.LoadReady, 1);
            check("load_word_count", bus.WordCount, i);
            check("load_mem_we", bus.MemWe, 1);
            check("load_mem_addr", bus.MemAddr, i);
            check("load_mem_wdata", bus.MemWData, d);
            exp_mem[i] = d;
            if (i == DEPTH - 1 && !bus.LoadLast) exp_ovf = 1'b1;
            step();
        end
        bus.LoadValid = 1'b0;
        bus.LoadLast  = 1'b0;
    endtask

    task automatic finish_load(input int n, input bit last);
        int fill_n;
        fill_n = 0;
`ifdef IMEM_ZERO_FILL_EN
        if (last && n < DEPTH) fill_n = DEPTH - n;
`endif
        for (int k = 0; k < fill_n; k++) begin
            @(negedge clk);
            check("fill_mem_we", bus.MemWe, 1);
            check("fill_mem_addr", bus.MemAddr, n + k);
            check("fill_mem_wdata", bus.MemWData, 0);
            check("fill_stall", bus.CpuStall, 1);
            check("fill_load_ready", bus.LoadReady, 0);
            exp_mem[n + k] = '0;
            step();
        end
        @(negedge clk);
        check("run_stall", bus.CpuStall, 0);
        check("run_load_ready", bus.LoadReady, 0);
        check("run_mem_we", bus.MemWe, 0);
        check("run_word_count", bus.WordCount, n);
        check("run_overflow", bus.OverflowErr, exp_ovf);
        step();
    endtask

    // first_addr/final_addr < 0 means random address.
    task automatic run_phase(input int first_addr, input int final_addr, input int ncyc);
        bit req;
        int addr;
        for (int k = 0; k < ncyc; k++) begin
            req  = (k == 0 && first_addr >= 0) ? 1'b1 : 1'($urandom_range(0, 1));
            addr = (k == 0 && first_addr >= 0) ? first_addr : $urandom_range(0, DEPTH - 1);
            bus.FetchReq     = req;
            bus.FetchAddress = IM'(addr);
            bus.Reload       = 1'b0;
            if (req) sb_q.push_back('{data: exp_mem[addr], due: cyc + 1});
            @(negedge clk);
            check("fetch_stall", bus.CpuStall, 0);
            check("fetch_mem_we", bus.MemWe, 0);
            if (req) check("fetch_mem_addr", bus.MemAddr, addr);
            step();
        end
        addr = (final_addr >= 0) ? final_addr : $urandom_range(0, DEPTH - 1);
        bus.FetchReq     = 1'b1;
        bus.FetchAddress = IM'(addr);
        bus.Reload       = 1'b1;
        sb_q.push_back('{data: exp_mem[addr], due: cyc + 1});
        @(negedge clk);
        check("reload_mem_addr", bus.MemAddr, addr);
        step();
        // DRAIN: a fetch and a reload presented here must both be ignored.
        bus.FetchAddress = IM'($urandom_range(0, DEPTH - 1));
        @(negedge clk);
        check("drain_stall", bus.CpuStall, 1);
        check("drain_mem_we", bus.MemWe, 0);
        check("drain_load_ready", bus.LoadReady, 0);
        step();
        bus.FetchReq = 1'b0;
        bus.Reload   = 1'b0;
        @(negedge clk);
        check("reload_load_ready", bus.LoadReady, 1);
        check("reload_stall", bus.CpuStall, 1);
        check("reload_word_count", bus.WordCount, 0);
        check("reload_overflow_kept", bus.OverflowErr, exp_ovf);
        step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_load_ready"}, bus.LoadReady, 1);
        check({tag, "_stall"}, bus.CpuStall, 1);
        check({tag, "_fetch_valid"}, bus.FetchValid, 0);
        check({tag, "_fetch_instr"}, bus.FetchInstruction, 0);
        check({tag, "_mem_we"}, bus.MemWe, 0);
        check({tag, "_mem_addr"}, bus.MemAddr, 0);
        check({tag, "_mem_wdata"}, bus.MemWData, 0);
        check({tag, "_word_count"}, bus.WordCount, 0);
        check({tag, "_overflow"}, bus.OverflowErr, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        logic [N-1:0] d;
        int lens [4];
        for (int i = 0; i < DEPTH; i++) begin
            seed_mem[i] = $urandom;
            exp_mem[i]  = seed_mem[i];
        end
        bus.LoadValid    = 1'b0;
        bus.LoadData     = '0;
        bus.LoadLast     = 1'b0;
        bus.Reload       = 1'b0;
        bus.FetchReq     = 1'b0;
        bus.FetchAddress = '0;
        exp_ovf          = 1'b0;

        #3;
        check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Three-word program, fetch of word 1 first, then reload together with a fetch of 0.
        load_words(3, 1'b1);
        finish_load(3, 1'b1);
        run_phase(1, 0, 8);

        // Overflow: a full memory with no end marker, then a 33rd word is refused.
        load_words(DEPTH, 1'b0);
        finish_load(DEPTH, 1'b0);
        bus.LoadValid = 1'b1;
        bus.LoadData  = $urandom;
        @(negedge clk);
        check("extra_word_ready", bus.LoadReady, 0);
        check("extra_word_we", bus.MemWe, 0);
        step();
        bus.LoadValid = 1'b0;
        run_phase(-1, -1, 10);

        // Random-length programs, including a full program that ends exactly at the last address.
        lens[0] = DEPTH;
        lens[1] = $urandom_range(1, DEPTH);
        lens[2] = $urandom_range(1, DEPTH);
        lens[3] = 1;
        for (int t = 0; t < 4; t++) begin
            n = lens[t];
            load_words(n, 1'b1);
            finish_load(n, 1'b1);
            run_phase(-1, -1, 12);
        end

        // Reset in the middle of the second word of a load.
        load_words(1, 1'b0);
        d             = $urandom;
        bus.LoadValid = 1'b1;
        bus.LoadData  = d;
        #2 rst_n = 1'b0;
        exp_ovf = 1'b0;
        #1;
        check_reset_outputs("midload_reset");
        @(posedge clk);
        #1;
        check("reset_held_mem_we", bus.MemWe, 0);
        bus.LoadValid = 1'b0;
        #1 rst_n = 1'b1;
        step();

        load_words(2, 1'b1);
        finish_load(2, 1'b1);
        run_phase(-1, -1, 12);

        repeat (3) step();
        check("pending_fetches", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
